// File: rtl/multi_repeater.sv
// multi_repeater: paced multi-target kick sequencer with completion, abort and missed-trigger tracking
module multi_repeater #(
    parameter int N_TARGET = 4,
    parameter int CNT_W    = 16,
    parameter int MARGIN_W = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                KICK,
    input  logic                ABORT,
    input  logic                MODE,
    input  logic                CONTINUOUS,
    input  logic                EXT_TRIG,
    input  logic [N_TARGET-1:0] TARGET_SEL,
    input  logic [CNT_W-1:0]    REPETITION,
    input  logic [MARGIN_W-1:0] POST_MARGIN,
    output logic [N_TARGET-1:0] TARGET_KICK,
    input  logic [N_TARGET-1:0] TARGET_BUSY,
    output logic                BUSY,
    output logic                DONE,
    output logic [CNT_W-1:0]    COUNT,
    output logic [CNT_W-1:0]    MISSED
);
    localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, WAIT_TGT = 2'd2, MARGIN = 2'd3;
    logic [1:0]          state;
    logic                kick_d, trig_d, mode_q, cont_q;
    logic [N_TARGET-1:0] sel_q;
    logic [CNT_W-1:0]    rep_q;
    logic [MARGIN_W-1:0] margin_q, mcnt;
    logic                kick_edge, trig_edge, tgt_idle, start, fire, wait_clr, end_chk, finish;

    // run-control decode; the kick cycle itself is recognised by TARGET_KICK still being high
    always_comb begin
        kick_edge = KICK & ~kick_d;
        trig_edge = EXT_TRIG & ~trig_d;
        tgt_idle  = (TARGET_BUSY & sel_q) == '0;
        start     = state == IDLE && kick_edge && !ABORT && TARGET_SEL != '0;
        fire      = state == EMIT && !ABORT && tgt_idle && (!mode_q || trig_edge);
        wait_clr  = state == WAIT_TGT && TARGET_KICK == '0 && tgt_idle;
        end_chk   = (wait_clr && margin_q == '0) || (state == MARGIN && mcnt == margin_q - MARGIN_W'(1));
        finish    = end_chk && !cont_q && COUNT == rep_q;
        BUSY      = state != IDLE;
    end

    // edge registers, settings latched while idle, counters and the run state machine
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            kick_d      <= 1'b1;
            trig_d      <= 1'b1;
            mode_q      <= 1'b0;
            cont_q      <= 1'b0;
            sel_q       <= '0;
            rep_q       <= '0;
            margin_q    <= '0;
            mcnt        <= '0;
            TARGET_KICK <= '0;
            DONE        <= 1'b0;
            COUNT       <= '0;
            MISSED      <= '0;
        end else begin
            kick_d      <= KICK;
            trig_d      <= EXT_TRIG;
            TARGET_KICK <= fire ? sel_q : '0;
            DONE        <= finish && !ABORT;
            if (state == IDLE) begin
                mode_q   <= MODE;
                cont_q   <= CONTINUOUS;
                sel_q    <= TARGET_SEL;
                rep_q    <= REPETITION == '0 ? CNT_W'(1) : REPETITION;
                margin_q <= POST_MARGIN;
            end
            if (start) begin
                COUNT  <= '0;
                MISSED <= '0;
            end else begin
                if (fire)
                    COUNT <= COUNT + CNT_W'(1);
                if (BUSY && mode_q && trig_edge && !fire && MISSED != '1)
                    MISSED <= MISSED + CNT_W'(1);
            end
            if (ABORT && state != IDLE)
                state <= IDLE;
            else if (start)
                state <= EMIT;
            else if (fire)
                state <= WAIT_TGT;
            else if (end_chk)
                state <= finish ? IDLE : EMIT;
            else if (wait_clr) begin
                state <= MARGIN;
                mcnt  <= '0;
            end else if (state == MARGIN)
                mcnt <= mcnt + MARGIN_W'(1);
        end
    end
endmodule
